apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave_pkg.sv | 23 ++
 rtl/apb_strb_merge.sv | 16 +
 rtl/apb_reg_slave.sv | 175 +++++++++++++++++
 tb/tb_apb_reg_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_reg_slave_pkg.sv
// Shared FSM state encoding and size derivations for apb_reg_slave.
// Register count is clamped to at least two so the register index is never zero-width.
package apb_reg_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  function automatic int reg_num_eff(input int reg_num);
    return (reg_num < 2) ? 2 : reg_num;
  endfunction

  function automatic int log2_reg(input int reg_num);
    return $clog2(reg_num_eff(reg_num));
  endfunction

  function automatic int log2_byte(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane merge: each byte comes from new_data_i when its strobe is set,
// otherwise the current register byte in old_data_i is kept.
module apb_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data_i,
  input  logic [DATA_WIDTH-1:0]   new_data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_lane
    assign merged_o[b*8 +: 8] = strb_i[b] ? new_data_i[b*8 +: 8] : old_data_i[b*8 +: 8];
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave bridging to a flat register bus with a fixed 3-cycle transfer.
// Define APB_REG_PSTRB_EN to honour pstrb via byte merge with the current register value.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for a setup phase; captures the request
// ST_WAIT | one-cycle decode; registers read data, error, write data
// ST_DONE | pready high for one cycle; write strobe if error-free
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_NUM        = 8,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [DATA_WIDTH/8-1:0]           pstrb,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pready,
  output logic                              pslverr,
  input  logic [REG_NUM*REG_DATA_WIDTH-1:0] reg_rdata_bus,
  output logic                              reg_apb_wen,
  output logic [REG_DATA_WIDTH-1:0]         reg_apb_wdata,
  output logic [log2_reg(REG_NUM)-1:0]      reg_apb_addr
);

  localparam int REG_NUM_EFF = reg_num_eff(REG_NUM);
  localparam int LOG2_REG    = log2_reg(REG_NUM);
  localparam int LOG2_BYTE   = log2_byte(DATA_WIDTH);
  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int ADDR_LIMIT  = REG_NUM * REG_DATA_WIDTH / 8;

  apb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic                      pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic                      wen_q, wen_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LOG2_REG-1:0]       addr_q, addr_d;

  logic [REG_DATA_WIDTH-1:0] regs [REG_NUM_EFF];
  logic [LOG2_REG-1:0]       idx;
  logic [REG_DATA_WIDTH-1:0] sel_data;
  logic [REG_DATA_WIDTH-1:0] merged_wdata;
  logic                      addr_err;

  // Indices past REG_NUM (only possible when REG_NUM < 2) read as zero.
  for (genvar k = 0; k < REG_NUM_EFF; k++) begin : g_regs
    if (k < REG_NUM) begin : g_real
      assign regs[k] = reg_rdata_bus[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
    end else begin : g_pad
      assign regs[k] = '0;
    end
  end

  assign idx      = paddr_q[LOG2_BYTE +: LOG2_REG];
  assign sel_data = regs[idx];
  assign addr_err = ((paddr_q & ADDR_WIDTH'(BYTES - 1)) != '0) ||
                    (paddr_q >= ADDR_WIDTH'(ADDR_LIMIT));

`ifdef APB_REG_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb_q, pstrb_d;

  apb_strb_merge #(
    .DATA_WIDTH (REG_DATA_WIDTH)
  ) u_strb_merge (
    .old_data_i (sel_data),
    .new_data_i (pwdata_q),
    .strb_i     (pstrb_q),
    .merged_o   (merged_wdata)
  );
`else
  logic unused_pstrb;
  assign unused_pstrb = ^pstrb;
  assign merged_wdata = pwdata_q;
`endif

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
`ifdef APB_REG_PSTRB_EN
    pstrb_d   = pstrb_q;
`endif
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d  = ST_WAIT;
          paddr_d  = paddr;
          pwrite_d = pwrite;
          pwdata_d = pwdata;
`ifdef APB_REG_PSTRB_EN
          pstrb_d  = pstrb;
`endif
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          pslverr_d = addr_err;
          if (!addr_err && !pwrite_q) prdata_d = sel_data;
          if (!addr_err && pwrite_q) begin
            wen_d   = 1'b1;
            wdata_d = merged_wdata;
            addr_d  = idx;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
`ifdef APB_REG_PSTRB_EN
      pstrb_q   <= '0;
`endif
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
`ifdef APB_REG_PSTRB_EN
      pstrb_q   <= pstrb_d;
`endif
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
    end
  end

  // A master dropping psel during DONE aborts the transfer, so the strobe is gated.
  assign reg_apb_wen   = wen_q & psel;
  assign prdata        = prdata_q;
  assign pready        = pready_q;
  assign pslverr       = pslverr_q;
  assign reg_apb_wdata = wdata_q;
  assign reg_apb_addr  = addr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: a transfer-level model predicts every output each cycle,
// and literal values pin the documented example transfers.
module tb_apb_reg_slave;

  logic        clk;
  logic        resetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [255:0] reg_rdata_bus;
  logic        reg_apb_wen;
  logic [31:0] reg_apb_wdata;
  logic [2:0]  reg_apb_addr;

  apb_reg_slave dut (
    .clk           (clk),
    .resetn        (resetn),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .pstrb         (pstrb),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr),
    .reg_rdata_bus (reg_rdata_bus),
    .reg_apb_wen   (reg_apb_wen),
    .reg_apb_wdata (reg_apb_wdata),
    .reg_apb_addr  (reg_apb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file the DUT writes into; it feeds reg_rdata_bus.
  logic [31:0] hw_mem [8] = '{32'h0000_0000, 32'hAABB_CCDD, 32'h2222_2222, 32'h3333_3333,
                              32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'hDEAD_BEEF};
  always @(posedge clk) if (reg_apb_wen) hw_mem[reg_apb_addr] <= reg_apb_wdata;
  always_comb for (int k = 0; k < 8; k++) reg_rdata_bus[k*32 +: 32] = hw_mem[k];

  // Reference register contents, updated when the model commits a write.
  logic [31:0] model_mem [8] = '{32'h0000_0000, 32'hAABB_CCDD, 32'h2222_2222, 32'h3333_3333,
                                 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'hDEAD_BEEF};

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_done = -1;
  logic        exp_write = 1'b0;
  logic        exp_err = 1'b0;
  int          exp_idx = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_wdata = '0;

  logic [31:0] act_prdata = '0, act_wdata = '0, act_addr = '0, act_err = '0, act_wen = '0;
  logic        done_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
    logic [31:0] old;
    exp_write = wr;
    exp_err   = (addr % 4 != 0) || (addr >= 32);
    exp_idx   = int'((addr / 4) % 8);
    old       = model_mem[exp_idx];
    exp_rdata = old;
`ifdef APB_REG_PSTRB_EN
    for (int b = 0; b < 4; b++) exp_wdata[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
`else
    exp_wdata = data;
    if (strb == 4'hx) exp_wdata = data;
`endif
  endtask

  // One APB transfer; returns during the DONE cycle so a next call is back-to-back.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input bit abort);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    predict(wr, addr, data, strb);
    exp_done = abort ? -1 : cyc + 2;
    if (!abort && wr && !exp_err) model_mem[exp_idx] = exp_wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    if (abort) begin
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  always @(negedge clk) begin
    done_now = (cyc == exp_done);
    chk("pready", 32'(pready), 32'(done_now));
    chk("pslverr", 32'(pslverr), 32'(done_now && exp_err));
    chk("prdata", prdata, (done_now && !exp_write && !exp_err) ? exp_rdata : 32'h0);
    chk("wen", 32'(reg_apb_wen), 32'(done_now && exp_write && !exp_err));
    if (done_now && exp_write && !exp_err) begin
      chk("waddr", 32'(reg_apb_addr), 32'(exp_idx));
      chk("wdata", reg_apb_wdata, exp_wdata);
    end
    if (done_now) begin
      act_prdata = prdata;
      act_wdata  = reg_apb_wdata;
      act_addr   = 32'(reg_apb_addr);
      act_err    = 32'(pslverr);
      act_wen    = 32'(reg_apb_wen);
    end
  end

  initial begin
    resetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", 32'(pready), 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_wen", 32'(reg_apb_wen), 32'h0);
    chk("rst_wdata", reg_apb_wdata, 32'h0);
    chk("rst_waddr", 32'(reg_apb_addr), 32'h0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    apb(1'b1, 32'h08, 32'h1234_5678, 4'hF, 1'b0); idle();
    chk("wr08_addr", act_addr, 32'd2);
    chk("wr08_wdata", act_wdata, 32'h1234_5678);
    chk("wr08_err", act_err, 32'd0);
    chk("wr08_wen", act_wen, 32'd1);

    apb(1'b0, 32'h1C, 32'h0, 4'h0, 1'b0); idle();
    chk("rd1C_data", act_prdata, 32'hDEAD_BEEF);
    chk("rd1C_err", act_err, 32'd0);

    apb(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0); idle();
    chk("wr20_err", act_err, 32'd1);
    chk("wr20_wen", act_wen, 32'd0);

    apb(1'b0, 32'h06, 32'h0, 4'h0, 1'b0); idle();
    chk("rd06_err", act_err, 32'd1);
    chk("rd06_data", act_prdata, 32'h0);

    apb(1'b1, 32'h04, 32'h1122_3344, 4'b0101, 1'b0); idle();
`ifdef APB_REG_PSTRB_EN
    chk("strb_wdata", act_wdata, 32'hAA22_CC44);
`else
    chk("strb_wdata", act_wdata, 32'h1122_3344);
`endif

    // Reset pulse during WAIT of a write: outputs clear at once, nothing is written.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h7777_7777; pstrb = 4'hF;
    exp_done = -1;
    @(posedge clk); #1;
    penable = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_pready", 32'(pready), 32'h0);
    chk("mid_rst_pslverr", 32'(pslverr), 32'h0);
    chk("mid_rst_wen", 32'(reg_apb_wen), 32'h0);
    chk("mid_rst_wdata", reg_apb_wdata, 32'h0);
    chk("mid_rst_waddr", 32'(reg_apb_addr), 32'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (3) idle();
    apb(1'b0, 32'h10, 32'h0, 4'h0, 1'b0); idle();
    chk("rd10_after_rst", act_prdata, 32'h4444_4444);

    apb(1'b1, 32'h00, 32'h55AA_1234, 4'hF, 1'b0);
    apb(1'b0, 32'h00, 32'h0, 4'h0, 1'b0); idle();
    chk("b2b_rd_data", act_prdata, 32'h55AA_1234);

    apb(1'b1, 32'h0C, 32'h9999_9999, 4'hF, 1'b1); idle();
    apb(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0); idle();
    chk("abort_rd_data", act_prdata, 32'h3333_3333);

    // penable high while idle must not start a transfer.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    repeat (4) @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
    apb(1'b0, 32'h00, 32'h0, 4'h0, 1'b0); idle();
    chk("penable_idle_rd", act_prdata, 32'h55AA_1234);

    apb(1'b0, 32'h14, 32'h0, 4'h0, 1'b0); idle();
    chk("rd14_data", act_prdata, 32'h5555_5555);

    repeat (3) idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
